spi_rx: RTL and testbench

Clock-domain SPI receiver that sits directly downstream of the team's 12-bit SPI master and consumes its `sclk`/`cs`/`mosi` lines. It oversamples the three lines on the system clock, reconstructs each LSB-first 12-bit frame, and presents it on a valid/ready word interface with a one-word holding register. It flags malformed frames and dropped words, and it is used both as the bench's reference slave and as the on-chip loopback checker.

---
 rtl/spi_rx.sv | 105 ++++++++++
 tb/tb_spi_rx.sv | 127 ++++++++++++
 2 files changed

// File: rtl/spi_rx.sv
// spi_rx: oversampling LSB-first SPI slave receiver with a one-word valid/ready holding register
module spi_rx #(
  parameter int DW   = 12,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs,
  input  logic          mosi,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          frame_err,
  output logic          overrun
);
  localparam int CW = $clog2(DW + 1);
  localparam int IW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} state_t;
  state_t          state;
  logic [SYNC-1:0] sclk_s, cs_s, mosi_s;
  logic            sclk_h, cs_h;
  logic [SYNC:0]   live;
  logic [CW-1:0]   bitcnt;
  logic [DW-1:0]   sh;
  logic            sclk_fall, cs_fall, cs_rise, mosi_q;
  // synchronizers at idle levels plus history flops; live marks when the history holds a real sample
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
      sclk_h <= 1'b0;
      cs_h   <= 1'b1;
      live   <= '0;
    end else begin
      sclk_s <= {sclk_s[SYNC-2:0], sclk};
      cs_s   <= {cs_s[SYNC-2:0], cs};
      mosi_s <= {mosi_s[SYNC-2:0], mosi};
      sclk_h <= sclk_s[SYNC-1];
      cs_h   <= cs_s[SYNC-1];
      live   <= {live[SYNC-1:0], 1'b1};
    end
  end
  // edges only count once the history flop reflects the real line, so a frame in flight at reset is ignored
  always_comb begin
    sclk_fall = live[SYNC] & sclk_h & ~sclk_s[SYNC-1];
    cs_fall   = live[SYNC] & cs_h & ~cs_s[SYNC-1];
    cs_rise   = live[SYNC] & ~cs_h & cs_s[SYNC-1];
    mosi_q    = mosi_s[SYNC-1];
  end
  // frame FSM, shift register and output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= '0;
      sh         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          bitcnt <= '0;
          sh     <= '0;
          busy   <= 1'b1;
          state  <= LEAD;
        end
        LEAD: if (cs_rise) begin
          frame_err <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end else if (sclk_fall) state <= SHIFT;
        SHIFT: if (cs_rise) begin
          frame_err <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end else if (sclk_fall) begin
          sh[bitcnt[IW-1:0]] <= mosi_q;
          bitcnt             <= bitcnt + CW'(1);
          if (bitcnt == CW'(DW - 1)) state <= DONE;
        end
        DONE: if (cs_rise) begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!dout_valid || dout_ready) begin
            dout       <= sh;
            dout_valid <= 1'b1;
          end else overrun <= 1'b1;
        end else if (sclk_fall) begin
          frame_err <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: directed frames from a behavioural master with hand-computed expected words
module tb_spi_rx;
  localparam int H = 5;
  logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0, dout_ready = 1'b0;
  logic [11:0] dout;
  logic        dout_valid, busy, frame_err, overrun;
  int          n_tests = 0, n_fail = 0, n_ferr = 0, n_ovr = 0;
  logic [11:0] words[$];

  always #5 clk = ~clk;

  spi_rx dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge clk) if (!rst) begin
    if (dout_valid && dout_ready) words.push_back(dout);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop();
    return words.size() > 0 ? 32'(words.pop_front()) : 32'hBAD0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] w, input int nbits, input int rst_at);
    sclk = 1'b1; cs = 1'b0; tick(H);
    sclk = 1'b0; tick(H);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1; mosi = i < 12 ? w[i] : 1'b0; tick(H);
      sclk = 1'b0; tick(H);
      if (i == rst_at) begin
        rst = 1'b1; tick(1); rst = 1'b0;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
      end
    end
    cs = 1'b1; mosi = 1'b0; tick(4 * H);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("reset_dout", dout, 0);
    check("reset_valid", dout_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun, 0);
    rst = 1'b0; tick(10);
    dout_ready = 1'b1; n_ferr = 0; n_ovr = 0;
    fork
      send(12'hA5C, 12, -1);
      begin tick(3 * H); check("busy_mid", busy, 1); end
    join
    check("a5c_count", words.size(), 1);
    check("a5c_word", pop(), 12'hA5C);
    check("a5c_ferr", n_ferr, 0);
    check("a5c_ovr", n_ovr, 0);
    check("a5c_busy", busy, 0);
    check("a5c_valid", dout_valid, 0);
    send(12'h000, 12, -1);
    send(12'hFFF, 12, -1);
    send(12'h001, 12, -1);
    check("b2b_count", words.size(), 3);
    check("b2b_w0", pop(), 12'h000);
    check("b2b_w1", pop(), 12'hFFF);
    check("b2b_w2", pop(), 12'h001);
    check("b2b_ferr", n_ferr, 0);
    dout_ready = 1'b0;
    send(12'h123, 12, -1);
    send(12'h456, 12, -1);
    check("ovr_dout", dout, 12'h123);
    check("ovr_valid", dout_valid, 1);
    check("ovr_pulses", n_ovr, 1);
    check("ovr_count", words.size(), 0);
    dout_ready = 1'b1; tick(2);
    check("ovr_drain_valid", dout_valid, 0);
    check("ovr_drain_word", pop(), 12'h123);
    check("ovr_drain_count", words.size(), 0);
    n_ovr = 0;
    send(12'hFFF, 5, -1);
    check("short_ferr", n_ferr, 1);
    check("short_valid", dout_valid, 0);
    check("short_count", words.size(), 0);
    send(12'h7E1, 12, -1);
    check("after_short_word", pop(), 12'h7E1);
    check("after_short_ferr", n_ferr, 1);
    n_ferr = 0;
    send(12'hABC, 13, -1);
    check("long_ferr", n_ferr, 1);
    check("long_count", words.size(), 0);
    check("long_valid", dout_valid, 0);
    n_ferr = 0;
    send(12'hBEE, 12, 5);
    check("rst_frame_ferr", n_ferr, 0);
    check("rst_frame_ovr", n_ovr, 0);
    check("rst_frame_count", words.size(), 0);
    send(12'h0F0, 12, -1);
    check("post_rst_word", pop(), 12'h0F0);
    check("post_rst_count", words.size(), 0);
    check("post_rst_ferr", n_ferr, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
